mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Sequences and shares the single byte-wide memory interface (16-bit address, separate read/write strobes, bit 15 selects ROM (0) or RAM (1)) between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Round-robin arbitration, per-region wait states, one transaction at a time.
- Rejects writes to ROM with an error pulse.
- Sits between the CPU front-end and the memory I/O block; the top level owns the tri-state of the internal data bus using `mem_wdata_oe`.

Parameters:
- ROM_WAIT, 2, extra ACCESS cycles for addresses with bit15=0 (0..15)
- RAM_WAIT, 1, extra ACCESS cycles for addresses with bit15=1 (0..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1 each  request from port 0 / port 1; held high until the matching ack
- we0, we1  input  1 each  1=write, 0=read; valid while req high
- addr0, addr1  input  16 each  byte address
- wdata0, wdata1  input  8 each  write data
- ack0, ack1  output  1 each  one-cycle completion pulse
- err  output  1  one-cycle pulse with ack when the write targeted ROM
- rdata  output  8  read data, valid in ack cycle, held until next read completes
- busy  output  1  high in any state other than IDLE
- mem_addr  output  16  to memory I/O address_in
- mem_read  output  1  to memory I/O read_memory
- mem_write  output  1  to memory I/O write_memory
- mem_wdata  output  8  value driven onto the internal data bus
- mem_wdata_oe  output  1  tri-state enable for mem_wdata
- mem_rdata  input  8  internal data bus sampled value

Behaviour:
- Reset: state=IDLE, last_grant=1 (port 0 wins first tie). All outputs 0 (ack0/1, err, rdata, busy, mem_addr, mem_read, mem_write, mem_wdata, mem_wdata_oe); wait counter 0. Reset asserted mid-transaction drops the strobes at the next edge; no ack is issued for the aborted transfer.
- Invariant: mem_read and mem_write are never both 1. mem_wdata_oe=1 only while mem_write=1.
- IDLE:
  - No req: remain in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port that is not last_grant, then update last_grant.
  - On grant: latch addr, we, wdata and port id into internal registers (later changes to inputs are ignored); go to SETUP.
- SETUP (1 cycle):
  - mem_addr=latched address; strobes low.
  - Load counter with ROM_WAIT if addr[15]=0, else RAM_WAIT.
  - If we=1 and addr[15]=0 (ROM write): go to DONE with err flagged; no strobe is ever asserted.
  - Otherwise: go to ACCESS.
- ACCESS (counter+1 cycles):
  - mem_read=~we, mem_write=we, mem_wdata_oe=we, mem_wdata=latched wdata; mem_addr held.
  - Counter decrements each cycle; when counter=0, capture mem_rdata into rdata if read, then go to DONE.
- DONE (1 cycle):
  - Strobes and oe low; mem_addr held.
  - ack of the granted port =1; err=1 if flagged; go to IDLE.
- Latency:
  - req sampled high in IDLE at edge n: SETUP in cycle n+1, ACCESS cycles n+2..n+2+W, ack in cycle n+3+W (W = wait count for the region).
  - ROM write error: ack+err in cycle n+2.
- Handshake:
  - Requester drops req in the cycle after it sees ack. A req still high when the arbiter is back in IDLE is a new request.
  - req dropped before ack: transaction still completes and ack is still pulsed.
  - A request arriving while busy waits; it is granted in IDLE, with round-robin giving it priority over the port just served.
- rdata unchanged by writes and by errored transactions.

Test Plan:
- Reset: assert reset 2 cycles mid-ACCESS -> mem_read/mem_write/ack/err/busy=0 the cycle after the first reset edge, state IDLE, no ack ever issued for the aborted access.
- RAM read, RAM_WAIT=1: req1, we1=0, addr1=16'h8010, mem_rdata=8'hA5 -> mem_read high exactly 2 cycles, mem_addr=8010, ack1 at n+4, rdata=A5, ack0 never asserted.
- ROM read, ROM_WAIT=2: req0, addr0=16'h0123, mem_rdata=8'h3C -> mem_read high 3 cycles, ack0 at n+5, rdata=3C.
- RAM write: req1, we1=1, addr1=16'hFFFF, wdata1=8'h5A -> mem_write=mem_wdata_oe=1 for 2 cycles, mem_wdata=5A, mem_read stays 0, ack1 at n+4, err=0, rdata unchanged.
- ROM write error: req1, we1=1, addr1=16'h0040 -> mem_write never 1, ack1 and err both high in cycle n+2.
- Contention: req0 and req1 both held continuously from reset, reads to RAM -> grants alternate 0,1,0,1; acks alternate; mem_read and mem_write never high together.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sequencer sharing one byte-wide memory port between fetch and load/store
module mem_access_arbiter #(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
  localparam logic [3:0] ROM_W = 4'(ROM_WAIT), RAM_W = 4'(RAM_WAIT);
  logic [1:0] state;
  logic       last_grant, lat_port, lat_we, err_flag;
  logic [3:0] cnt;
  logic       gnt;
  logic       rom_write;
  assign gnt = (req0 && req1) ? ~last_grant : req1;
  assign rom_write = lat_we && !mem_addr[15];
  // Transaction sequencer: grant and latch in IDLE, then SETUP -> ACCESS (wait states) -> DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      err_flag   <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          state      <= SETUP;
          lat_port   <= gnt;
          last_grant <= gnt;
          lat_we     <= gnt ? we1 : we0;
          mem_addr   <= gnt ? addr1 : addr0;
          mem_wdata  <= gnt ? wdata1 : wdata0;
        end
        SETUP: begin
          cnt      <= mem_addr[15] ? RAM_W : ROM_W;
          err_flag <= rom_write;
          state    <= rom_write ? DONE : ACCESS;
        end
        ACCESS: if (cnt == 4'd0) begin
          if (!lat_we) rdata <= mem_rdata;
          state <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
  assign busy         = state != IDLE;
  assign mem_read     = state == ACCESS && !lat_we;
  assign mem_write    = state == ACCESS && lat_we;
  assign mem_wdata_oe = mem_write;
  assign ack0         = state == DONE && !lat_port;
  assign ack1         = state == DONE && lat_port;
  assign err          = state == DONE && err_flag;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;
  logic clk = 0, reset = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic ack0, ack1, err, busy, mem_read, mem_write, mem_wdata_oe;
  logic [7:0] rdata, mem_wdata;
  logic [15:0] mem_addr;
  int checks = 0, errors = 0;
  int ack_cyc, n_rd, n_wr, n_oe, other_ack, overlap, err_at_ack;
  logic [15:0] seen_addr;
  logic [7:0] seen_wdata, rdata_at_ack;

  mem_access_arbiter #(.ROM_WAIT(2), .RAM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic p, input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rd);
    ack_cyc = 0; n_rd = 0; n_wr = 0; n_oe = 0; other_ack = 0; overlap = 0; err_at_ack = 0;
    seen_addr = 0; seen_wdata = 0; rdata_at_ack = 0;
    mem_rdata = rd;
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    for (int i = 1; i <= 12 && ack_cyc == 0; i++) begin
      tick();
      if (i == 1) begin addr0 = 16'h7777; addr1 = 16'h7777; wdata0 = 8'hEE; wdata1 = 8'hEE; end
      if (mem_read) n_rd++;
      if (mem_write) begin n_wr++; seen_wdata = mem_wdata; end
      if (mem_wdata_oe) n_oe++;
      if (mem_read || mem_write) seen_addr = mem_addr;
      if ((mem_read && mem_write) || (mem_wdata_oe && !mem_write)) overlap++;
      if (p ? ack0 : ack1) other_ack++;
      if (p ? ack1 : ack0) begin
        ack_cyc = i; err_at_ack = int'(err); rdata_at_ack = rdata;
        req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    checks++; if ({ack0, ack1, err, busy, mem_read, mem_write, mem_wdata_oe} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000000", {ack0, ack1, err, busy, mem_read, mem_write, mem_wdata_oe}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", mem_wdata); end
    req0 = 1; we0 = 0; addr0 = 16'h0123; mem_rdata = 8'h11;
    tick(); tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL abort_pre_read got %b want 1", mem_read); end
    req0 = 0; reset = 1;
    tick();
    checks++; if ({mem_read, mem_write, ack0, ack1, err, busy} !== 6'b0) begin errors++; $display("FAIL abort_drop got %b want 000000", {mem_read, mem_write, ack0, ack1, err, busy}); end
    tick();
    reset = 0;
    other_ack = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (ack0 || ack1 || busy) other_ack++; end
    checks++; if (other_ack != 0) begin errors++; $display("FAIL abort_no_ack got %0d want 0", other_ack); end
  endtask

  task automatic test_ram_read();
    do_txn(1'b1, 1'b0, 16'h8010, 8'h00, 8'hA5);
    checks++; if (ack_cyc != 4) begin errors++; $display("FAIL ram_rd_lat got %0d want 4", ack_cyc); end
    checks++; if (n_rd != 2) begin errors++; $display("FAIL ram_rd_strobes got %0d want 2", n_rd); end
    checks++; if (seen_addr !== 16'h8010) begin errors++; $display("FAIL ram_rd_addr got %h want 8010", seen_addr); end
    checks++; if (rdata_at_ack !== 8'hA5) begin errors++; $display("FAIL ram_rd_data got %h want a5", rdata_at_ack); end
    checks++; if (other_ack != 0 || n_wr != 0 || err_at_ack != 0) begin errors++; $display("FAIL ram_rd_side got ack0=%0d wr=%0d err=%0d want 0", other_ack, n_wr, err_at_ack); end
  endtask

  task automatic test_rom_read();
    do_txn(1'b0, 1'b0, 16'h0123, 8'h00, 8'h3C);
    checks++; if (ack_cyc != 5) begin errors++; $display("FAIL rom_rd_lat got %0d want 5", ack_cyc); end
    checks++; if (n_rd != 3) begin errors++; $display("FAIL rom_rd_strobes got %0d want 3", n_rd); end
    checks++; if (seen_addr !== 16'h0123) begin errors++; $display("FAIL rom_rd_addr got %h want 0123", seen_addr); end
    checks++; if (rdata_at_ack !== 8'h3C) begin errors++; $display("FAIL rom_rd_data got %h want 3c", rdata_at_ack); end
    checks++; if (other_ack != 0) begin errors++; $display("FAIL rom_rd_other got %0d want 0", other_ack); end
  endtask

  task automatic test_ram_write();
    do_txn(1'b1, 1'b1, 16'hFFFF, 8'h5A, 8'h99);
    checks++; if (ack_cyc != 4) begin errors++; $display("FAIL ram_wr_lat got %0d want 4", ack_cyc); end
    checks++; if (n_wr != 2 || n_oe != 2) begin errors++; $display("FAIL ram_wr_strobes got wr=%0d oe=%0d want 2", n_wr, n_oe); end
    checks++; if (seen_wdata !== 8'h5A) begin errors++; $display("FAIL ram_wr_data got %h want 5a", seen_wdata); end
    checks++; if (seen_addr !== 16'hFFFF) begin errors++; $display("FAIL ram_wr_addr got %h want ffff", seen_addr); end
    checks++; if (n_rd != 0 || err_at_ack != 0 || overlap != 0) begin errors++; $display("FAIL ram_wr_side got rd=%0d err=%0d ovl=%0d want 0", n_rd, err_at_ack, overlap); end
    checks++; if (rdata_at_ack !== 8'h3C) begin errors++; $display("FAIL ram_wr_rdata got %h want 3c", rdata_at_ack); end
  endtask

  task automatic test_rom_write_err();
    do_txn(1'b1, 1'b1, 16'h0040, 8'h77, 8'h99);
    checks++; if (ack_cyc != 2) begin errors++; $display("FAIL rom_wr_lat got %0d want 2", ack_cyc); end
    checks++; if (err_at_ack != 1) begin errors++; $display("FAIL rom_wr_err got %0d want 1", err_at_ack); end
    checks++; if (n_wr != 0 || n_rd != 0 || n_oe != 0) begin errors++; $display("FAIL rom_wr_strobes got wr=%0d rd=%0d oe=%0d want 0", n_wr, n_rd, n_oe); end
    checks++; if (rdata_at_ack !== 8'h3C) begin errors++; $display("FAIL rom_wr_rdata got %h want 3c", rdata_at_ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rom_wr_err_pulse got %b want 0", err); end
  endtask

  task automatic test_contention();
    int seq [4];
    int k;
    k = 0; overlap = 0;
    reset = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h8000; addr1 = 16'h8001; mem_rdata = 8'h42;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      tick();
      if ((mem_read && mem_write) || (ack0 && ack1)) overlap++;
      if (ack0) begin seq[k] = 0; k++; end
      else if (ack1) begin seq[k] = 1; k++; end
    end
    req0 = 0; req1 = 0;
    tick(); tick();
    checks++; if (k != 4) begin errors++; $display("FAIL cont_count got %0d want 4", k); end
    else begin
      checks++; if (seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin errors++; $display("FAIL cont_order got %0d%0d%0d%0d want 0101", seq[0], seq[1], seq[2], seq[3]); end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL cont_overlap got %0d want 0", overlap); end
    checks++; if (rdata !== 8'h42) begin errors++; $display("FAIL cont_rdata got %h want 42", rdata); end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_rom_read();
    test_ram_write();
    test_rom_write_err();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
